// File: rtl/wfg_drive_ser_pkg.sv
// Shared types and default widths for the serial pattern driver.
package wfg_drive_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } ser_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 5;

endpackage

// File: rtl/wfg_drive_ser_buf.sv
// One-entry holding register for the next stimulus word: push loads it, pop empties it.
module wfg_drive_ser_buf
    import wfg_drive_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Push and pop together only happens when empty: the word bypasses straight to the consumer.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push_i) begin
            data_d = data_i;
        end
        if (flush_i) begin
            full_d = 1'b0;
        end else if (push_i && !pop_i) begin
            full_d = 1'b1;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/wfg_drive_ser.sv
// Serial pattern driver: shifts a bit range of each stimulus word out, one bit per subcycle.
// Optional word counter output enabled by defining WFG_DRIVE_SER_WORDCNT_EN.
module wfg_drive_ser
    import wfg_drive_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              wfg_core_start_i,
    input  logic              wfg_core_sync_i,
    input  logic              wfg_core_subcycle_i,
    input  logic [IDX_W-1:0]  wfg_ser_begin_i,
    input  logic [IDX_W-1:0]  wfg_ser_end_i,
    input  logic [DATA_W-1:0] wfg_ser_data_i,
    input  logic              wfg_ser_valid_i,
    output logic              wfg_ser_ready_o,
    output logic              wfg_ser_o,
    output logic              wfg_ser_oe_o,
    output logic              wfg_ser_underrun_o,
    output logic              active_o
`ifdef WFG_DRIVE_SER_WORDCNT_EN
    ,
    output logic [15:0]       wfg_ser_word_cnt_o
`endif
);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  end_q, end_d;
    logic              out_q, out_d;
    logic              oe_q, oe_d;
    logic              und_q, und_d;
`ifdef WFG_DRIVE_SER_WORDCNT_EN
    logic [15:0]       cnt_q, cnt_d;
`endif

    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              xfer, word_avail, reload;
    logic [DATA_W-1:0] next_word;
    logic [IDX_W-1:0]  idx_inc;

    assign wfg_ser_ready_o = en_i & (state_q != IDLE) & ~hold_full;
    assign xfer            = wfg_ser_valid_i & wfg_ser_ready_o;
    assign word_avail      = hold_full | xfer;
    assign next_word       = hold_full ? hold_data : wfg_ser_data_i;
    assign reload          = en_i & (state_q != IDLE) & wfg_core_sync_i & word_avail;
    assign idx_inc         = idx_q + 1'b1;

    wfg_drive_ser_buf #(.DATA_W(DATA_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (~en_i),
        .push_i  (xfer),
        .pop_i   (reload),
        .data_i  (wfg_ser_data_i),
        .full_o  (hold_full),
        .data_o  (hold_data)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        end_d   = end_q;
        out_d   = out_q;
        oe_d    = oe_q;
        und_d   = und_q;
`ifdef WFG_DRIVE_SER_WORDCNT_EN
        cnt_d   = cnt_q;
`endif
        if (!en_i) begin
            state_d = IDLE;
            out_d   = 1'b0;
            oe_d    = 1'b0;
        end else if (state_q == IDLE) begin
            out_d = 1'b0;
            oe_d  = 1'b0;
            if (wfg_core_start_i) begin
                state_d = ARMED;
                und_d   = 1'b0;
`ifdef WFG_DRIVE_SER_WORDCNT_EN
                cnt_d   = '0;
`endif
            end
        end else if (wfg_core_sync_i) begin
            if (reload) begin
                // A reversed range collapses to a single bit at begin.
                state_d = RUN;
                word_d  = next_word;
                idx_d   = wfg_ser_begin_i;
                end_d   = (wfg_ser_end_i < wfg_ser_begin_i) ? wfg_ser_begin_i : wfg_ser_end_i;
                out_d   = next_word[wfg_ser_begin_i];
                oe_d    = 1'b1;
`ifdef WFG_DRIVE_SER_WORDCNT_EN
                cnt_d   = cnt_q + 16'd1;
`endif
            end else if (state_q == RUN) begin
                state_d = ARMED;
                und_d   = 1'b1;
                out_d   = 1'b0;
                oe_d    = 1'b0;
            end
        end else if (wfg_core_subcycle_i && state_q == RUN && idx_q != end_q) begin
            idx_d = idx_inc;
            out_d = word_q[idx_inc];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            end_q   <= '0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
            und_q   <= 1'b0;
`ifdef WFG_DRIVE_SER_WORDCNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            und_q   <= und_d;
`ifdef WFG_DRIVE_SER_WORDCNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign wfg_ser_o          = out_q;
    assign wfg_ser_oe_o       = oe_q;
    assign wfg_ser_underrun_o = und_q;
    assign active_o           = (state_q != IDLE);
`ifdef WFG_DRIVE_SER_WORDCNT_EN
    assign wfg_ser_word_cnt_o = cnt_q;
`endif

endmodule
